vec_stream_reader: RTL

//  Downstream drain stage of the SIMD core. After a kernel completes, it reads
//  256-bit result lines from data-memory port B. It serialises each line into
//  16-bit lane words on a valid/ready stream toward the output/display side.
//  It owns dmem port B while busy; the core keeps port A.

---
 rtl/vec_stream_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vec_stream_reader.sv
// Drains result lines from dmem port B and streams them out as 16-bit lane words.
// Optional STREAM_LAST_EN adds out_last, which marks the final word of a transfer.
module vec_stream_reader #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 32,
  parameter int LINE_B = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_lines,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef STREAM_LAST_EN
  output logic              out_last,
`endif
  output logic              busy,
  output logic              done
);

  localparam int LANES  = LINE_W / WORD_W;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [ADDR_W-1:0]             r_line_addr;
  logic [ADDR_W-1:0]             r_mem_addr;
  logic [15:0]                   r_lines_left;
  logic [LANE_W-1:0]             r_lane;
  logic [LANES-1:0][WORD_W-1:0]  r_line;

  logic                          w_hs;
  logic                          w_last_lane;
  logic                          w_last_line;
  logic [ADDR_W-1:0]             w_next_addr;
  logic [ADDR_W-1:0]             w_req_addr;

  assign w_hs        = (r_state == S_SHIFT) && out_ready;
  assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
  assign w_last_line = (r_lines_left == 16'd1);
  assign w_next_addr = r_line_addr + ADDR_W'(LINE_B);
  // The first request comes straight from the start inputs; later ones from the stride.
  assign w_req_addr  = (r_state == S_IDLE) ? base_addr : w_next_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (num_lines == 16'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:   w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_SHIFT;
      S_SHIFT: begin
        if (w_hs && w_last_lane) begin
          w_next_state = w_last_line ? S_DONE : S_REQ;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_addr  <= '0;
      r_mem_addr   <= '0;
      r_lines_left <= '0;
      r_lane       <= '0;
      r_line       <= '0;
    end else begin
      if (w_next_state == S_REQ) begin
        r_mem_addr <= w_req_addr;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_line_addr  <= base_addr;
            r_lines_left <= num_lines;
          end
        end
        S_WAIT: begin
          r_line <= mem_rdata;
          r_lane <= '0;
        end
        S_SHIFT: begin
          if (w_hs) begin
            r_lane <= r_lane + 1'b1;
            if (w_last_lane) begin
              r_line_addr  <= w_next_addr;
              r_lines_left <= r_lines_left - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign out_valid = (r_state == S_SHIFT);
  assign out_data  = out_valid ? r_line[r_lane] : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
`ifdef STREAM_LAST_EN
  assign out_last  = out_valid && w_last_lane && w_last_line;
`endif

endmodule
